// File: rtl/mem_arbiter.sv
//==============================================================================
// mem_arbiter - data-priority RAM arbiter with bounded instruction starvation.
// Revision 1.0
//==============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramrdy,
  output logic              busy
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] dstreak_q, dstreak_d;
  logic          dreq;
  logic          force_i;

  assign dreq    = dREN | dWEN;
  assign force_i = iREN && (MAX_DSTREAK != 0) && (dstreak_q == STREAK_MAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // The streak only moves on a grant edge, never during a held grant.
        if (dreq && !force_i) begin
          state_d = DATA;
          if (!iREN)
            dstreak_d = '0;
          else if (dstreak_q != STREAK_MAX)
            dstreak_d = dstreak_q + 1'b1;
        end else if (iREN) begin
          state_d   = INSTR;
          dstreak_d = '0;
        end
      end

      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dhit     = ramrdy & dreq;
        if (dhit)
          dload = ramload;
        if (dhit || !dreq)
          state_d = IDLE;
      end

      INSTR: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        ihit    = ramrdy & iREN;
        if (ihit)
          iload = ramload;
        if (ihit || !iREN)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// tb_mem_arbiter - directed scenarios plus random traffic against a cycle model.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN, ramrdy;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dstore, ramload;
  logic [DW-1:0] iload, dload, ramstore;
  logic [AW-1:0] ramaddr;
  logic          ihit, dhit, ramREN, ramWEN, busy;

  int checks   = 0;
  int failures = 0;

  // Model owner of the bus: 0 = nobody, 1 = data port, 2 = instruction port.
  int m_owner;
  int m_streak;

  logic last_ihit, last_dhit, last_busy, last_ren, last_wen;
  logic [DW-1:0] last_iload, last_dload, last_store;
  logic [AW-1:0] last_addr;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramrdy(ramrdy), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven; checks the cycle and
  // advances the model across the next rising edge.
  task automatic cycle();
    logic          e_ren, e_wen, e_ihit, e_dhit, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store, e_iload, e_dload;
    int            n_owner, n_streak;
    logic          want_d, starve;
    #1;
    if (!nRST) begin
      m_owner  = 0;
      m_streak = 0;
    end
    want_d  = dREN | dWEN;
    e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0;
    e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_busy = (m_owner != 0);
    n_owner  = m_owner;
    n_streak = m_streak;
    if (m_owner == 1) begin
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_dhit  = ramrdy && want_d;
      e_dload = e_dhit ? ramload : '0;
      if (e_dhit || !want_d) n_owner = 0;
    end else if (m_owner == 2) begin
      e_addr  = iaddr;
      e_ren   = iREN;
      e_ihit  = ramrdy && iREN;
      e_iload = e_ihit ? ramload : '0;
      if (e_ihit || !iREN) n_owner = 0;
    end else begin
      starve = iREN && (MAXD != 0) && (m_streak == MAXD);
      if (want_d && !starve) begin
        n_owner  = 1;
        n_streak = iREN ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
      end else if (iREN) begin
        n_owner  = 2;
        n_streak = 0;
      end
    end
    chk("ramREN",   ramREN,   e_ren);
    chk("ramWEN",   ramWEN,   e_wen);
    chk("ramaddr",  ramaddr,  e_addr);
    chk("ramstore", ramstore, e_store);
    chk("ihit",     ihit,     e_ihit);
    chk("dhit",     dhit,     e_dhit);
    chk("iload",    iload,    e_iload);
    chk("dload",    dload,    e_dload);
    chk("busy",     busy,     e_busy);
    last_ihit = ihit;  last_dhit = dhit;  last_busy = busy;
    last_ren  = ramREN; last_wen = ramWEN; last_addr = ramaddr;
    last_store = ramstore; last_iload = iload; last_dload = dload;
    @(posedge CLK);
    if (nRST) begin
      m_owner  = n_owner;
      m_streak = n_streak;
    end else begin
      m_owner  = 0;
      m_streak = 0;
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [5:0] seq;
    int         nhits;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; ramrdy = 1'b1;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h1234_5678;
    m_owner = 0; m_streak = 0;
    @(negedge CLK);

    // Reset holds everything quiet even with requests and ramrdy up.
    cycle();
    chk("rst_busy", last_busy, 0);
    chk("rst_ren",  last_ren,  0);
    chk("rst_ihit", last_ihit, 0);
    nRST = 1'b1;
    cycle();
    chk("rel_idle_ihit", last_ihit, 0);
    cycle();
    chk("rel_busy", last_busy, 1);
    chk("rel_ihit", last_ihit, 1);
    iREN = 1'b0;
    cycle();

    // Instruction fetch with three wait cycles.
    iREN = 1'b1; iaddr = 32'h0000_0040; ramrdy = 1'b0; ramload = 32'h8C22_0004;
    cycle();
    chk("fetch_c0_ren", last_ren, 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("fetch_wait_ren",  last_ren,  1);
      chk("fetch_wait_addr", last_addr, 32'h40);
    end
    ramrdy = 1'b1;
    cycle();
    chk("fetch_ihit",  last_ihit,  1);
    chk("fetch_iload", last_iload, 32'h8C22_0004);
    iREN = 1'b0; ramrdy = 1'b0;
    cycle();
    chk("fetch_done_busy", last_busy, 0);

    // Data write beats a simultaneous instruction request.
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramrdy = 1'b1;
    cycle();
    cycle();
    chk("prio_wen",   last_wen,   1);
    chk("prio_store", last_store, 32'hDEAD_BEEF);
    chk("prio_dhit",  last_dhit,  1);
    dWEN = 1'b0;
    cycle();
    chk("prio_gap_busy", last_busy, 0);
    cycle();
    chk("prio_instr_ren", last_ren,  1);
    chk("prio_instr_hit", last_ihit, 1);

    // Starvation guard: expect D, D, I, D, D, I with both sides always asking.
    dREN = 1'b1; seq = '0; nhits = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if ((last_dhit || last_ihit) && nhits < 6) begin
        seq = {seq[4:0], last_dhit};
        nhits++;
      end
    end
    chk("starve_nhits", nhits, 6);
    chk("starve_seq",   seq,   6'b110110);
    iREN = 1'b0; dREN = 1'b0;
    cycle();
    cycle();

    // Withdrawn data read aborts without a hit.
    dREN = 1'b1; ramrdy = 1'b0; daddr = 32'h200;
    cycle();
    cycle();
    chk("abort_pre_ren", last_ren, 1);
    dREN = 1'b0;
    cycle();
    chk("abort_ren",  last_ren,  0);
    chk("abort_dhit", last_dhit, 0);
    cycle();
    chk("abort_busy", last_busy, 0);

    // Asynchronous reset in the middle of a fetch.
    iREN = 1'b1; iaddr = 32'h80;
    cycle();
    cycle();
    chk("mid_pre_busy", last_busy, 1);
    nRST = 1'b0;
    cycle();
    chk("mid_rst_ren",  last_ren,  0);
    chk("mid_rst_busy", last_busy, 0);
    nRST = 1'b1; ramrdy = 1'b1;
    cycle();
    chk("mid_rel_ihit0", last_ihit, 0);
    cycle();
    chk("mid_rel_ihit1", last_ihit, 1);
    iREN = 1'b0;
    cycle();

    // Random traffic, including reset pulses and conflicting strobes.
    for (int i = 0; i < 3000; i++) begin
      nRST    = ($urandom_range(0, 99) != 0);
      iREN    = ($urandom_range(0, 3) != 0);
      dREN    = ($urandom_range(0, 2) == 0);
      dWEN    = ($urandom_range(0, 3) == 0);
      ramrdy  = ($urandom_range(0, 2) == 0);
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      cycle();
      chk("excl_hit",    last_ihit & last_dhit, 0);
      chk("excl_strobe", last_ren & last_wen,   0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
